// File: rtl/exu_pipe.sv
// exu_pipe: execute stage with a one-entry skid register, single-cycle
// ALU and an iterative shift-add multiply / restoring divide core.
module exu_pipe #(
    parameter int XLEN   = 32,
    parameter int SIDE_W = 128,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [XLEN-1:0]   in_src1,
    input  logic [XLEN-1:0]   in_src2,
    input  logic [SIDE_W-1:0] in_side,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_result,
    output logic              out_zero,
    output logic [SIDE_W-1:0] out_side,
    output logic              busy
);
    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ITER = 2'd1;
    localparam logic [1:0] S_ONE  = 2'd2;

    localparam logic [OP_W-1:0] OP_IMM    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_ADD    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_SUB    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AND    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_XOR    = OP_W'(4);
    localparam logic [OP_W-1:0] OP_OR     = OP_W'(5);
    localparam logic [OP_W-1:0] OP_SL     = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SR     = OP_W'(7);
    localparam logic [OP_W-1:0] OP_DIV    = OP_W'(8);
    localparam logic [OP_W-1:0] OP_SSR    = OP_W'(9);
    localparam logic [OP_W-1:0] OP_SLES   = OP_W'(10);
    localparam logic [OP_W-1:0] OP_ULES   = OP_W'(11);
    localparam logic [OP_W-1:0] OP_REMU   = OP_W'(12);
    localparam logic [OP_W-1:0] OP_MUL    = OP_W'(13);
    localparam logic [OP_W-1:0] OP_DIVU   = OP_W'(14);
    localparam logic [OP_W-1:0] OP_REM    = OP_W'(15);
    localparam logic [OP_W-1:0] OP_SRC    = OP_W'(16);
    localparam logic [OP_W-1:0] OP_MULHU  = OP_W'(17);
    localparam logic [OP_W-1:0] OP_MULH   = OP_W'(18);
    localparam logic [OP_W-1:0] OP_MULHSU = OP_W'(19);

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CW-1:0]   ITERS   = CW'(XLEN);

    function automatic logic [XLEN-1:0] alu(
        input logic [OP_W-1:0] op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SHW-1:0]  sh;
        logic [XLEN-1:0] r;
        sh = b[SHW-1:0];
        case (op)
            OP_IMM:  r = b;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_OR:   r = a | b;
            OP_SL:   r = a << sh;
            OP_SR:   r = a >> sh;
            OP_SSR:  r = $signed(a) >>> sh;
            OP_SLES: r = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
            OP_ULES: r = {{(XLEN-1){1'b0}}, a < b};
            OP_SRC:  r = a;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]        state_q, state_d;
    logic              skid_vld_q, skid_vld_d;
    logic [OP_W-1:0]   skid_op_q, skid_op_d;
    logic [XLEN-1:0]   skid_s1_q, skid_s1_d;
    logic [XLEN-1:0]   skid_s2_q, skid_s2_d;
    logic [SIDE_W-1:0] skid_side_q, skid_side_d;
    logic              rdy_q, rdy_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;
    logic [XLEN-1:0]   den_q, den_d;
    logic              neg_q, neg_d;
    logic              div_q, div_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic              zero_q, zero_d;
    logic [SIDE_W-1:0] side_q, side_d;

    logic              core_free, accept, load;
    logic [OP_W-1:0]   ld_op;
    logic [XLEN-1:0]   ld_s1, ld_s2;
    logic [SIDE_W-1:0] ld_side;
    logic              ld_md, ld_div, ld_rem, ld_sa, ld_sb;
    logic              a_neg, b_neg, dz, ovf, ld_iter;
    logic [XLEN-1:0]   a_mag, b_mag, one_res;

    logic [XLEN:0]     msum, rsh;
    logic [XLEN-1:0]   rsub, it_hi, it_lo;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo, rmd, fin_res;

    assign in_ready   = rdy_q;
    assign out_valid  = (state_q == S_ONE);
    assign out_result = res_q;
    assign out_zero   = zero_q;
    assign out_side   = side_q;

    assign accept    = in_valid && rdy_q;
    assign core_free = (state_q == S_IDLE) ||
                       ((state_q == S_ONE) && out_ready);
    assign load      = !flush && core_free && (skid_vld_q || accept);
    assign busy      = (state_q != S_IDLE) || skid_vld_q || accept;

    // pick the op to load (skid has priority) and classify it
    always_comb begin
        ld_op   = skid_vld_q ? skid_op_q   : in_op;
        ld_s1   = skid_vld_q ? skid_s1_q   : in_src1;
        ld_s2   = skid_vld_q ? skid_s2_q   : in_src2;
        ld_side = skid_vld_q ? skid_side_q : in_side;
        ld_md   = 1'b0;
        ld_div  = 1'b0;
        ld_rem  = 1'b0;
        ld_sa   = 1'b0;
        ld_sb   = 1'b0;
        case (ld_op)
            OP_MUL:    ld_md = 1'b1;
            OP_MULHU:  ld_md = 1'b1;
            OP_MULH:   begin ld_md = 1'b1; ld_sa = 1'b1; ld_sb = 1'b1; end
            OP_MULHSU: begin ld_md = 1'b1; ld_sa = 1'b1; end
            OP_DIVU:   begin ld_md = 1'b1; ld_div = 1'b1; end
            OP_REMU:   begin ld_md = 1'b1; ld_div = 1'b1; ld_rem = 1'b1; end
            OP_DIV: begin
                ld_md = 1'b1; ld_div = 1'b1; ld_sa = 1'b1; ld_sb = 1'b1;
            end
            OP_REM: begin
                ld_md = 1'b1; ld_div = 1'b1; ld_rem = 1'b1;
                ld_sa = 1'b1; ld_sb = 1'b1;
            end
            default: ;
        endcase
        a_neg   = ld_sa && ld_s1[XLEN-1];
        b_neg   = ld_sb && ld_s2[XLEN-1];
        a_mag   = a_neg ? -ld_s1 : ld_s1;
        b_mag   = b_neg ? -ld_s2 : ld_s2;
        dz      = ld_div && (ld_s2 == '0);
        ovf     = ld_div && ld_sa && (ld_s1 == MIN_NEG) && (ld_s2 == '1);
        ld_iter = ld_md && !dz && !ovf;
        if (dz)
            one_res = ld_rem ? ld_s1 : '1;
        else if (ovf)
            one_res = ld_rem ? '0 : ld_s1;
        else
            one_res = alu(ld_op, ld_s1, ld_s2);
    end

    // one multiply or divide iteration on the magnitudes
    always_comb begin
        msum = lo_q[0] ? ({1'b0, hi_q} + {1'b0, den_q}) : {1'b0, hi_q};
        rsh  = {hi_q, lo_q[XLEN-1]};
        rsub = rsh[XLEN-1:0] - den_q;
        if (div_q) begin
            if (rsh >= {1'b0, den_q}) begin
                it_hi = rsub;
                it_lo = {lo_q[XLEN-2:0], 1'b1};
            end else begin
                it_hi = rsh[XLEN-1:0];
                it_lo = {lo_q[XLEN-2:0], 1'b0};
            end
        end else begin
            it_hi = msum[XLEN:1];
            it_lo = {msum[0], lo_q[XLEN-1:1]};
        end
    end

    // sign fix-up and selection of the iterative result
    always_comb begin
        prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo      = neg_q ? -lo_q : lo_q;
        rmd      = neg_q ? -hi_q : hi_q;
        case (op_q)
            OP_MUL:                        fin_res = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHU, OP_MULHSU:  fin_res = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fin_res = quo;
            OP_REM, OP_REMU:               fin_res = rmd;
            default:                       fin_res = '0;
        endcase
    end

    // skid register and its registered empty flag
    always_comb begin
        skid_vld_d  = skid_vld_q;
        skid_op_d   = skid_op_q;
        skid_s1_d   = skid_s1_q;
        skid_s2_d   = skid_s2_q;
        skid_side_d = skid_side_q;
        if (flush) begin
            skid_vld_d = 1'b0;
        end else if (skid_vld_q && load) begin
            skid_vld_d = 1'b0;
        end else if (accept && !load) begin
            skid_vld_d  = 1'b1;
            skid_op_d   = in_op;
            skid_s1_d   = in_src1;
            skid_s2_d   = in_src2;
            skid_side_d = in_side;
        end
        rdy_d = !skid_vld_d;
    end

    // core FSM: load, iterate, hold result until handshake
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        den_d   = den_q;
        neg_d   = neg_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        zero_d  = zero_q;
        side_d  = side_q;
        if (load) begin
            op_d   = ld_op;
            side_d = ld_side;
            div_d  = ld_div;
            cnt_d  = '0;
            hi_d   = '0;
            if (ld_iter) begin
                state_d = S_ITER;
                lo_d    = ld_div ? a_mag : b_mag;
                den_d   = ld_div ? b_mag : a_mag;
                neg_d   = ld_rem ? a_neg : (a_neg ^ b_neg);
            end else begin
                state_d = S_ONE;
                res_d   = one_res;
                zero_d  = ((ld_op == OP_ADD) || (ld_op == OP_SUB)) &&
                          (one_res == '0);
            end
        end else if (state_q == S_ITER) begin
            if (cnt_q == ITERS) begin
                state_d = S_ONE;
                res_d   = fin_res;
                zero_d  = 1'b0;
            end else begin
                hi_d  = it_hi;
                lo_d  = it_lo;
                cnt_d = cnt_q + CW'(1);
            end
        end else if ((state_q == S_ONE) && out_ready) begin
            state_d = S_IDLE;
        end
        if (flush)
            state_d = S_IDLE;
    end

    // state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            skid_vld_q  <= 1'b0;
            skid_op_q   <= '0;
            skid_s1_q   <= '0;
            skid_s2_q   <= '0;
            skid_side_q <= '0;
            rdy_q       <= 1'b0;
            op_q        <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            den_q       <= '0;
            neg_q       <= 1'b0;
            div_q       <= 1'b0;
            cnt_q       <= '0;
            res_q       <= '0;
            zero_q      <= 1'b0;
            side_q      <= '0;
        end else begin
            state_q     <= state_d;
            skid_vld_q  <= skid_vld_d;
            skid_op_q   <= skid_op_d;
            skid_s1_q   <= skid_s1_d;
            skid_s2_q   <= skid_s2_d;
            skid_side_q <= skid_side_d;
            rdy_q       <= rdy_d;
            op_q        <= op_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            den_q       <= den_d;
            neg_q       <= neg_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            zero_q      <= zero_d;
            side_q      <= side_d;
        end
    end

endmodule

// File: tb/tb_exu_pipe.sv
// tb_exu_pipe: vector table plus scoreboard bench for exu_pipe,
// with a second 16-bit instance for the width parameter.
module tb_exu_pipe;
    localparam int XL = 32;
    localparam int SW = 128;

    localparam logic [4:0] IMM = 5'd0, ADD = 5'd1, SUB = 5'd2, AND = 5'd3;
    localparam logic [4:0] XOR = 5'd4, OR = 5'd5, SL = 5'd6, SR = 5'd7;
    localparam logic [4:0] DIV = 5'd8, SSR = 5'd9, SLES = 5'd10;
    localparam logic [4:0] ULES = 5'd11, REMU = 5'd12, MUL = 5'd13;
    localparam logic [4:0] DIVU = 5'd14, REM = 5'd15, SRC = 5'd16;
    localparam logic [4:0] MULHU = 5'd17, MULH = 5'd18, MULHSU = 5'd19;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [4:0]    in_op = '0;
    logic [XL-1:0] in_src1 = '0;
    logic [XL-1:0] in_src2 = '0;
    logic [SW-1:0] in_side = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [XL-1:0] out_result;
    logic          out_zero;
    logic [SW-1:0] out_side;
    logic          busy;

    logic          in_valid16 = 1'b0;
    logic          in_ready16;
    logic [4:0]    in_op16 = '0;
    logic [15:0]   in_src1_16 = '0;
    logic [15:0]   in_src2_16 = '0;
    logic [7:0]    in_side16 = '0;
    logic          out_valid16;
    logic [15:0]   out_result16;
    logic          out_zero16;
    logic [7:0]    out_side16;
    logic          busy16;

    always #5 clk = ~clk;

    exu_pipe #(.XLEN(XL), .SIDE_W(SW), .OP_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_src1(in_src1), .in_src2(in_src2), .in_side(in_side),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_side(out_side), .busy(busy)
    );

    exu_pipe #(.XLEN(16), .SIDE_W(8), .OP_W(5)) dut16 (
        .clk(clk), .rst(rst), .flush(1'b0),
        .in_valid(in_valid16), .in_ready(in_ready16), .in_op(in_op16),
        .in_src1(in_src1_16), .in_src2(in_src2_16), .in_side(in_side16),
        .out_valid(out_valid16), .out_ready(1'b1),
        .out_result(out_result16), .out_zero(out_zero16),
        .out_side(out_side16), .busy(busy16)
    );

    typedef struct {
        logic [4:0]    op;
        logic [XL-1:0] a;
        logic [XL-1:0] b;
        logic [XL-1:0] exp;
        logic          zero;
        int            lat;
    } vec_t;

    typedef struct {
        logic [XL-1:0] res;
        logic          zero;
        logic [SW-1:0] side;
        int            due;
        bit            chk_lat;
    } sb_t;

    localparam int NV = 27;
    vec_t tv[NV];
    sb_t  sb[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   stalls = 0;
    bit   lat_seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: latency on first sight, data on handshake
    always @(negedge clk) begin
        #1;
        if (rst && out_valid) begin
            if (sb.size() == 0) begin
                chk("spurious_valid", 128'(out_valid), 128'(0));
            end else begin
                if (!lat_seen) begin
                    lat_seen = 1'b1;
                    if (sb[0].chk_lat)
                        chk("latency", 128'(cyc), 128'(sb[0].due));
                end
                if (out_ready) begin
                    chk("result", 128'(out_result), 128'(sb[0].res));
                    chk("zero", 128'(out_zero), 128'(sb[0].zero));
                    chk("side", out_side, sb[0].side);
                    void'(sb.pop_front());
                    lat_seen = 1'b0;
                end
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [XL-1:0] a,
                        input logic [XL-1:0] b, input logic [XL-1:0] exp,
                        input logic zero, input int lat, input bit cl);
        int n = 0;
        in_valid = 1'b1;
        in_op    = op;
        in_src1  = a;
        in_src2  = b;
        in_side  = {$urandom(), $urandom(), $urandom(), $urandom()};
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        stalls += n;
        if (!in_ready)
            chk("accept_timeout", 128'(in_ready), 128'(1));
        else
            sb.push_back('{res: exp, zero: zero, side: in_side,
                           due: cyc + 1 + lat, chk_lat: cl});
        @(negedge clk);
    endtask

    task automatic drain(input int lim);
        int n = 0;
        in_valid = 1'b0;
        while (sb.size() != 0 && n < lim) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("drain", 128'(sb.size()), 128'(0));
        sb.delete();
        lat_seen = 1'b0;
        @(negedge clk);
    endtask

    task automatic run16(input logic [4:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] exp);
        int n = 0;
        int acc;
        in_valid16 = 1'b1;
        in_op16    = op;
        in_src1_16 = a;
        in_src2_16 = b;
        in_side16  = 8'h5A;
        acc = cyc + 1;
        @(negedge clk);
        in_valid16 = 1'b0;
        while (!out_valid16 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("x16_latency", 128'(cyc), 128'(acc + 17));
        chk("x16_result", 128'(out_result16), 128'(exp));
        chk("x16_side", 128'(out_side16), 128'(8'h5A));
        @(negedge clk);
    endtask

    initial begin
        int n_up;
        int t0;
        tv[0]  = '{ADD,    32'd5,         32'hFFFF_FFFB, 32'd0,         1'b1, 0};
        tv[1]  = '{SSR,    32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0, 0};
        tv[2]  = '{ULES,   32'd1,         32'hFFFF_FFFF, 32'd1,         1'b0, 0};
        tv[3]  = '{SUB,    32'd9,         32'd3,         32'd6,         1'b0, 0};
        tv[4]  = '{SUB,    32'd4,         32'd4,         32'd0,         1'b1, 0};
        tv[5]  = '{XOR,    32'd5,         32'd5,         32'd0,         1'b0, 0};
        tv[6]  = '{AND,    32'hF0F0,      32'hFF00,      32'hF000,      1'b0, 0};
        tv[7]  = '{OR,     32'hF0F0,      32'hFF00,      32'hFFF0,      1'b0, 0};
        tv[8]  = '{SL,     32'd1,         32'd33,        32'd2,         1'b0, 0};
        tv[9]  = '{SR,     32'h8000_0000, 32'd4,         32'h0800_0000, 1'b0, 0};
        tv[10] = '{SLES,   32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 0};
        tv[11] = '{IMM,    32'hDEAD,      32'h1234,      32'h1234,      1'b0, 0};
        tv[12] = '{SRC,    32'hABCD,      32'h1,         32'hABCD,      1'b0, 0};
        tv[13] = '{5'd20,  32'd7,         32'd9,         32'd0,         1'b0, 0};
        tv[14] = '{MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1'b0, XL + 1};
        tv[15] = '{MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         1'b0, XL + 1};
        tv[16] = '{MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, XL + 1};
        tv[17] = '{MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 1'b0, XL + 1};
        tv[18] = '{MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, XL + 1};
        tv[19] = '{DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, XL + 1};
        tv[20] = '{REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0, XL + 1};
        tv[21] = '{DIVU,   32'd100,       32'd7,         32'd14,        1'b0, XL + 1};
        tv[22] = '{REMU,   32'd100,       32'd7,         32'd2,         1'b0, XL + 1};
        tv[23] = '{DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0, 0};
        tv[24] = '{REMU,   32'd7,         32'd0,         32'd7,         1'b0, 0};
        tv[25] = '{DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 0};
        tv[26] = '{REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1'b0, 0};

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_result", 128'(out_result), 128'(0));
        chk("rst_zero", 128'(out_zero), 128'(0));
        chk("rst_side", out_side, 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        chk("rst16_in_ready", 128'(in_ready16), 128'(0));
        rst = 1'b1;
        #1;
        chk("rel_in_ready_low", 128'(in_ready), 128'(0));
        @(posedge clk);
        #1;
        chk("rel_in_ready_high", 128'(in_ready), 128'(1));
        @(negedge clk);

        // vector table, each op on an idle core
        for (int i = 0; i < NV; i++) begin
            send(tv[i].op, tv[i].a, tv[i].b, tv[i].exp, tv[i].zero,
                 tv[i].lat, 1'b1);
            drain(60);
        end

        // back-to-back stream
        stalls = 0;
        for (int i = 0; i < 8; i++)
            send(ADD, XL'(i * 3), XL'(100 + i), XL'(i * 3 + 100 + i),
                 1'b0, 0, 1'b1);
        chk("stream_stalls", 128'(stalls), 128'(0));
        drain(20);

        // backpressure: core plus skid then in_ready low
        out_ready = 1'b0;
        send(ADD, 32'd1, 32'd1, 32'd2, 1'b0, 0, 1'b1);
        send(ADD, 32'd2, 32'd2, 32'd4, 1'b0, 0, 1'b0);
        in_valid = 1'b0;
        chk("bp_in_ready", 128'(in_ready), 128'(0));
        repeat (3) @(negedge clk);
        chk("bp_hold_valid", 128'(out_valid), 128'(1));
        chk("bp_hold_result", 128'(out_result), 128'(2));
        chk("bp_still_full", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        send(ADD, 32'd3, 32'd3, 32'd6, 1'b0, 0, 1'b0);
        drain(20);

        // flush at iteration 10 of a divide with the skid full
        in_valid = 1'b1;
        in_op    = DIVU;
        in_src1  = 32'd1000;
        in_src2  = 32'd3;
        in_side  = 128'h1;
        chk("fl_ready", 128'(in_ready), 128'(1));
        t0 = cyc + 1;
        @(negedge clk);
        in_op   = ADD;
        in_src1 = 32'd1;
        in_src2 = 32'd1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("fl_skid_full", 128'(in_ready), 128'(0));
        while (cyc < t0 + 9) @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("fl_out_valid", 128'(out_valid), 128'(0));
        chk("fl_skid_empty", 128'(in_ready), 128'(1));
        chk("fl_busy", 128'(busy), 128'(0));
        n_up = 0;
        repeat (XL + 5) begin
            @(negedge clk);
            #1;
            if (out_valid) n_up++;
        end
        chk("fl_no_result", 128'(n_up), 128'(0));
        @(negedge clk);

        // accept and flush in the same cycle: flush wins
        in_valid = 1'b1;
        in_op    = ADD;
        in_src1  = 32'd8;
        in_src2  = 32'd8;
        flush    = 1'b1;
        chk("af_ready", 128'(in_ready), 128'(1));
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        n_up = 0;
        repeat (3) begin
            #1;
            if (out_valid) n_up++;
            @(negedge clk);
        end
        chk("af_no_result", 128'(n_up), 128'(0));
        chk("af_busy", 128'(busy), 128'(0));
        send(ADD, 32'd3, 32'd4, 32'd7, 1'b0, 0, 1'b1);
        drain(20);

        // reset asserted mid-multiply
        in_valid = 1'b1;
        in_op    = MUL;
        in_src1  = 32'd12345;
        in_src2  = 32'd678;
        in_side  = 128'hA5A5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("mr_out_valid", 128'(out_valid), 128'(0));
        chk("mr_in_ready", 128'(in_ready), 128'(0));
        chk("mr_result", 128'(out_result), 128'(0));
        chk("mr_zero", 128'(out_zero), 128'(0));
        chk("mr_side", out_side, 128'(0));
        chk("mr_busy", 128'(busy), 128'(0));
        sb.delete();
        lat_seen = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send(SUB, 32'd10, 32'd4, 32'd6, 1'b0, 0, 1'b1);
        drain(20);

        // 16-bit instance
        run16(MUL, 16'h0100, 16'h0100, 16'h0000);
        run16(MULHU, 16'h0100, 16'h0100, 16'h0001);
        run16(DIV, 16'hFFF9, 16'h0002, 16'hFFFD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
